fifo_rd_stream_dna: RTL and testbench

Read-side controller for the DNA sample FIFO. It tracks FIFO occupancy from the producer's write strobe and issues read addresses to the synchronous-read RAM (1-cycle latency). Returned words are presented on a valid/ready stream through a 2-entry output buffer. It sits between the FIFO RAM and the downstream DNA-processing consumer and sustains one word per cycle while the consumer keeps ready high.

---
 rtl/fifo_rd_stream_dna.sv | 109 ++++++++++
 tb/tb_fifo_rd_stream_dna.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_dna.sv
// Read-side FIFO controller: occupancy tracking, sync-RAM read issue,
// 2-entry valid/ready output buffer.
// Ports: clk, reset (async low), wr, ram_rd_en, r_addr, ram_rd_data,
//        m_valid, m_data, m_ready, count, empty, full, overflow.
module fifo_rd_stream_dna #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] FULL_C =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [1:0]            occ_q, occ_d, occ_p;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  ovf_q, ovf_d;
  logic                  pop, wr_acc;
  logic [2:0]            held;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = buf0_q;
  assign pop      = m_valid & m_ready;
  assign count    = count_q;
  assign r_addr   = r_addr_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_C);
  assign overflow = ovf_q;

  // Words that will occupy the buffer after this edge,
  // excluding any read issued now.
  assign held = {1'b0, occ_q} + {2'b0, inflight_q}
              - {2'b0, pop};

  assign ram_rd_en = ~empty & (held < 3'd2);

  // A same-cycle issue frees a slot, so a write while full
  // is still accepted then.
  assign wr_acc = wr & (~full | ram_rd_en);

  always_comb begin
    count_d  = count_q;
    r_addr_d = r_addr_q;
    ovf_d    = ovf_q | (wr & ~wr_acc);
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    occ_p    = occ_q - {1'b0, pop};

    if (wr_acc & ~ram_rd_en)
      count_d = count_q + ONE_C;
    else if (~wr_acc & ram_rd_en)
      count_d = count_q - ONE_C;

    if (ram_rd_en)
      r_addr_d = r_addr_q + 1'b1;

    if (pop)
      buf0_d = buf1_q;

    // Returning data lands behind whatever survives the pop.
    if (inflight_q) begin
      if (occ_p == 2'd0)
        buf0_d = ram_rd_data;
      else
        buf1_d = ram_rd_data;
    end

    occ_d = occ_p + {1'b0, inflight_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      r_addr_q   <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      r_addr_q   <= r_addr_d;
      occ_q      <= occ_d;
      inflight_q <= ram_rd_en;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_dna.sv
// Bench for fifo_rd_stream_dna: RAM model, queue-based reference,
// directed scenarios plus random traffic.
module tb_fifo_rd_stream_dna;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr = 1'b0;
  logic          ram_rd_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] ram_rd_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [AW:0]   count;
  logic          empty, full, overflow;

  fifo_rd_stream_dna #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .wr(wr),
    .ram_rd_en(ram_rd_en), .r_addr(r_addr),
    .ram_rd_data(ram_rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] wdata = '0;
  logic          wr_ok = 1'b0;

  assign ram_rd_data = ram_q;

  // Producer-side RAM: only words the FIFO accepts are stored.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
    end else begin
      if (ram_rd_en) ram_q <= mem[r_addr];
      if (wr_ok) begin
        mem[wptr] <= wdata;
        wptr <= wptr + 1'b1;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference: words in RAM, words buffered, read in flight,
  // issued-read count, and the in-order list of undelivered words.
  int cnt_m, occ_m, infl_m, raddr_m;
  bit ovf_m;
  logic [DW-1:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    cnt_m = 0; occ_m = 0; infl_m = 0; raddr_m = 0;
    ovf_m = 1'b0;
    q.delete();
  endtask

  task automatic step(input bit w, input bit r,
                      input logic [DW-1:0] d);
    bit pop, iss, acc;
    @(negedge clk);
    wr = w; m_ready = r; wdata = d;
    #1;
    pop = (occ_m > 0) && r;
    iss = (cnt_m > 0) && (occ_m + infl_m - int'(pop) < 2);
    acc = w && (cnt_m < DEPTH || iss);
    chk("ram_rd_en", ram_rd_en, iss);
    chk("r_addr", r_addr, raddr_m);
    chk("count", count, cnt_m);
    chk("empty", empty, cnt_m == 0);
    chk("full", full, cnt_m == DEPTH);
    chk("overflow", overflow, ovf_m);
    chk("m_valid", m_valid, occ_m > 0);
    if (occ_m > 0) chk("m_data", m_data, q[0]);
    wr_ok = acc;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    if (w && !acc) ovf_m = 1'b1;
    occ_m   = occ_m - int'(pop) + infl_m;
    infl_m  = int'(iss);
    cnt_m   = cnt_m + int'(acc) - int'(iss);
    raddr_m = (raddr_m + int'(iss)) % DEPTH;
  endtask

  // Reset is asserted mid-cycle so an in-flight read can be caught.
  task automatic do_reset();
    @(negedge clk);
    wr = 1'b0; m_ready = 1'b0; wr_ok = 1'b0;
    #1;
    chk("rd_en_at_rst", ram_rd_en,
        (cnt_m > 0) && (occ_m + infl_m < 2));
    #1 reset = 1'b0;
    #1;
    clear_model();
    chk("rst_r_addr", r_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    repeat (3) begin
      @(negedge clk);
      wr = ~wr;
    end
    @(negedge clk);
    wr = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    clear_model();
    do_reset();
    repeat (2) step(1'b0, 1'b1, 8'h00);

    // Single word
    step(1'b1, 1'b1, 8'hA5);
    repeat (3) step(1'b0, 1'b1, 8'h00);
    chk("single_r_addr", r_addr, 1);

    // Streaming with address wrap
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(i % 16));
    repeat (4) step(1'b0, 1'b1, 8'h00);
    chk("wrap_r_addr", r_addr, 4);

    // Backpressure
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
    repeat (3) step(1'b0, 1'b0, 8'h00);
    chk("bp_count", count, 3);
    chk("bp_m_data", m_data, 8'h50);
    repeat (6) step(1'b0, 1'b1, 8'h00);

    // Full and overflow
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 8'h00);
    chk("full_count", count, 16);
    chk("full_flag", full, 1);
    step(1'b1, 1'b0, 8'hEE);
    step(1'b0, 1'b0, 8'h00);
    chk("ovf_flag", overflow, 1);
    repeat (22) step(1'b0, 1'b1, 8'h00);
    chk("ovf_sticky", overflow, 1);

    // Reset mid-stream with a read in flight
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h90 + i));
    do_reset();
    repeat (2) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h3C);
    repeat (4) step(1'b0, 1'b1, 8'h00);

    // Random traffic with shifting write/ready bias
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int wb, rb;
      wb = (i / 100) % 3;
      rb = (i / 150) % 2;
      step(($urandom_range(0, 3) < 1 + wb),
           ($urandom_range(0, 3) < 2 + rb) || (i % 97 < 3) == 0
             ? $urandom_range(0, 3) != 0 : 1'b0,
           8'($urandom));
    end
    repeat (24) step(1'b0, 1'b1, 8'h00);
    chk("drain_empty", empty, 1);
    chk("drain_m_valid", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
